floatmul_pipe: RTL and testbench

Parametrised, fully pipelined floating-point multiplier. It joins two valid/ready operand streams (a, b) and emits one rounded product per accepted pair. It supports backpressure, bubble collapsing and IEEE-style special-case handling. It sits wherever a streaming datapath needs a sustained one-multiply-per-cycle FP product, with configurable format width and latency.

---
 rtl/floatmul_pkg.sv | 26 ++
 rtl/floatmul_pipe_reg.sv | 41 ++++
 rtl/floatmul_pipe.sv | 173 +++++++++++++++++
 tb/tb_floatmul_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/floatmul_pkg.sv
// Shared types, flag positions and format helpers for the pipelined FP multiplier.
package floatmul_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } float32_t;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/floatmul_pipe_reg.sv
// One elastic pipeline slot: loads whenever it is empty or its occupant leaves this cycle.
module floatmul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         down_free,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!valid_q || down_free) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/floatmul_pipe.sv
// Streaming FP multiplier: joins two operand streams, classifies in stage 0,
// multiplies significands into stage 1 and rounds/packs at the last stage output.
module floatmul_pipe
    import floatmul_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int STAGES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      busy,
    input  logic                      a_valid,
    input  logic [EXP_W+FRAC_W:0]     a_payload,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [EXP_W+FRAC_W:0]     b_payload,
    output logic                      b_ready,
    output logic                      o_valid,
    output logic [EXP_W+FRAC_W:0]     o_payload,
    output logic [3:0]                o_flags,
    input  logic                      o_ready
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int E_W    = EXP_W + 2;
    localparam int DATA_W = 3 + E_W + PROD_W;
    localparam int BIAS   = fp_bias(EXP_W);
    localparam logic [E_W-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};

    // Slot record: {sign, class, exponent, significands-or-product}
    logic [STAGES:0]       free;
    logic [STAGES-1:0]     stage_valid;
    logic [STAGES-1:0]     stage_in_valid;
    logic [DATA_W-1:0]     stage_data [STAGES];

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    // Ready ripples from the consumer back through every slot that is empty or leaving.
    always_comb begin
        free[STAGES] = o_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free[k] = !stage_valid[k] || free[k+1];
        end
    end

    assign a_ready        = rst_n && b_valid && free[0];
    assign b_ready        = rst_n && a_valid && free[0];
    assign stage_in_valid = {stage_valid[STAGES-2:0], a_valid && b_valid};
    assign busy           = a_valid || b_valid || (rst_n && (|stage_valid));

    fp_class_e         cls_a, cls_b, cls_p;
    logic              s0_sign;
    logic [E_W-1:0]    s0_exp;
    logic [DATA_W-1:0] s0_data;

    always_comb begin
        cls_a   = classify(a_payload[W-2 -: EXP_W], a_payload[FRAC_W-1:0]);
        cls_b   = classify(b_payload[W-2 -: EXP_W], b_payload[FRAC_W-1:0]);
        s0_sign = a_payload[W-1] ^ b_payload[W-1];
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            cls_p = CLS_NAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            cls_p = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            cls_p = CLS_ZERO;
        end else begin
            cls_p = CLS_NORM;
        end
        s0_exp  = {2'b00, a_payload[W-2 -: EXP_W]} + {2'b00, b_payload[W-2 -: EXP_W]} - E_W'(BIAS);
        s0_data = {s0_sign, cls_p, s0_exp,
                   1'b1, a_payload[FRAC_W-1:0], 1'b1, b_payload[FRAC_W-1:0]};
    end

    logic [PROD_W-1:0] mul_a, mul_b, mul_p;

    assign mul_a = {{SIG_W{1'b0}}, stage_data[0][PROD_W-1 -: SIG_W]};
    assign mul_b = {{SIG_W{1'b0}}, stage_data[0][SIG_W-1:0]};
    assign mul_p = mul_a * mul_b;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [DATA_W-1:0] d_in;
            if (gi == 0) begin : g_in_classify
                assign d_in = s0_data;
            end else if (gi == 1) begin : g_in_multiply
                assign d_in = {stage_data[0][DATA_W-1 -: 3+E_W], mul_p};
            end else begin : g_in_pass
                assign d_in = stage_data[gi-1];
            end

            floatmul_pipe_reg #(
                .W(DATA_W)
            ) u_reg (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (stage_in_valid[gi]),
                .in_data  (d_in),
                .down_free(free[gi+1]),
                .valid    (stage_valid[gi]),
                .data     (stage_data[gi])
            );
        end
    endgenerate

    logic [DATA_W-1:0] last_d;
    logic              r_sign;
    logic [1:0]        r_cls;
    logic [E_W-1:0]    r_exp, e_adj, e_r;
    logic [PROD_W-1:0] r_prod;
    logic [PROD_W-2:0] norm_low;
    logic [FRAC_W-1:0] frac_t;
    logic [FRAC_W:0]   frac_r;
    logic              guard, sticky, round_up;
    logic [W-1:0]      res;
    logic [3:0]        res_flags;

    always_comb begin
        last_d   = stage_data[STAGES-1];
        r_sign   = last_d[DATA_W-1];
        r_cls    = last_d[DATA_W-2 -: 2];
        r_exp    = last_d[PROD_W +: E_W];
        r_prod   = last_d[PROD_W-1:0];
        // Drop the leading one; a product >= 2.0 shifts the binary point one place.
        norm_low = r_prod[PROD_W-1] ? r_prod[PROD_W-2:0] : {r_prod[PROD_W-3:0], 1'b0};
        e_adj    = r_exp + {{(E_W-1){1'b0}}, r_prod[PROD_W-1]};
        frac_t   = norm_low[PROD_W-2 -: FRAC_W];
        guard    = norm_low[FRAC_W];
        sticky   = |norm_low[FRAC_W-1:0];
        round_up = guard && (sticky || frac_t[0]);
        frac_r   = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
        e_r      = e_adj + {{(E_W-1){1'b0}}, frac_r[FRAC_W]};

        res       = '0;
        res_flags = '0;
        case (r_cls)
            CLS_NAN: begin
                res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                res_flags[FLAG_INVALID] = 1'b1;
            end
            CLS_INF:  res = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            CLS_ZERO: res = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
            default: begin
                if (!e_r[E_W-1] && (e_r >= EXP_ONES)) begin
                    res = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    res_flags[FLAG_OVERFLOW] = 1'b1;
                    res_flags[FLAG_INEXACT]  = 1'b1;
                end else if (e_r[E_W-1] || (e_r == '0)) begin
                    res = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                    res_flags[FLAG_UNDERFLOW] = 1'b1;
                    res_flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    res = {r_sign, e_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
                    res_flags[FLAG_INEXACT] = guard || sticky;
                end
            end
        endcase
    end

    assign o_valid   = rst_n && stage_valid[STAGES-1];
    assign o_payload = o_valid ? res : '0;
    assign o_flags   = o_valid ? res_flags : 4'b0000;

endmodule

// File: tb/tb_floatmul_pipe.sv
// Randomised and directed bench for floatmul_pipe against an arithmetic reference model.
module tb_floatmul_pipe;
    import floatmul_pkg::*;

    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst_n, busy;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_payload, b_payload, o_payload;
    logic        o_valid, o_ready;
    logic [3:0]  o_flags;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] res;
    } txn_t;
    txn_t exp_q[$];

    floatmul_pipe #(.EXP_W(8), .FRAC_W(23), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .busy(busy),
        .a_valid(a_valid), .a_payload(a_payload), .a_ready(a_ready),
        .b_valid(b_valid), .b_payload(b_payload), .b_ready(b_ready),
        .o_valid(o_valid), .o_payload(o_payload), .o_flags(o_flags), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference: exact integer product, then round-to-nearest-even on the remainder.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e, sh;
        longint fa, fb, p, q, rem, half;
        bit     za, zb, ia, ib, na, nb, inx;
        logic   s;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = longint'(a[22:0]); fb = longint'(b[22:0]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255 && fa == 0); ib = (eb == 255 && fb == 0);
        na = (ea == 255 && fa != 0); nb = (eb == 255 && fb != 0);
        s  = a[31] ^ b[31];
        if (na || nb || (ia && zb) || (ib && za)) return {4'b1000, 32'h7FC00000};
        if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
        if (za || zb) return {4'b0000, s, 31'd0};
        p  = ((longint'(1) << 23) | fa) * ((longint'(1) << 23) | fb);
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (longint'(1) << 47)) begin
            e++;
            sh = 24;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          r;
        r = $urandom_range(0, 19);
        f = 23'($urandom);
        case (r)
            0: e = 8'h00;
            1: begin e = 8'hFF; f = '0; end
            2: begin e = 8'hFF; f[0] = 1'b1; end
            3: e = 8'($urandom_range(1, 8));
            4: e = 8'($urandom_range(240, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    // Scoreboard: every output handshake is checked in order; stalled outputs must hold.
    logic        stall_prev = 1'b0;
    logic [35:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_hold", 36'(o_valid), 36'd1);
                check("stall_payload_hold", {o_flags, o_payload}, held);
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h expected=none", {o_flags, o_payload});
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    n_pop++;
                    $display("txn %0d a=%h b=%h prod=%h flags=%b", n_pop, t.a, t.b, o_payload, o_flags);
                    check("result", {o_flags, o_payload}, t.res);
                end
            end
            if (a_valid && b_valid && a_ready && b_ready)
                exp_q.push_back('{a_payload, b_payload, ref_mul(a_payload, b_payload)});
            stall_prev = o_valid && !o_ready;
            held       = {o_flags, o_payload};
        end
    end

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ep, input logic [3:0] ef, input string nm);
        @(posedge clk); #1;
        o_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_payload = a; b_payload = b;
        @(negedge clk);
        check({nm, "_accept"}, 36'(a_ready), 36'd1);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, "_not_early"}, 36'(o_valid), 36'd0);
        check({nm, "_busy"}, 36'(busy), 36'd1);
        @(posedge clk); #1;
        check({nm, "_valid_lat3"}, 36'(o_valid), 36'd1);
        check({nm, "_literal"}, {o_flags, o_payload}, {ef, ep});
    endtask

    logic [31:0] ops_a [20];
    logic [31:0] ops_b [20];
    int          idx;
    int          pops_before;

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
        a_payload = '0; b_payload = '0;
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b1; b_valid = 1'b1; a_payload = 32'h3F800000; b_payload = 32'h3F800000;
        @(negedge clk);
        check("rst_o_valid", 36'(o_valid), 36'd0);
        check("rst_a_ready", 36'(a_ready), 36'd0);
        check("rst_b_ready", 36'(b_ready), 36'd0);
        check("rst_out", {o_flags, o_payload}, 36'd0);
        check("rst_busy_inputs", 36'(busy), 36'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("idle_o_valid", 36'(o_valid), 36'd0);
        check("idle_busy", 36'(busy), 36'd0);

        directed(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul_1p5x2");
        directed(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "inexact");
        directed(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, "overflow");
        directed(32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000, "inf_x_zero");
        directed(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, "nan_x_one");
        directed(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, "underflow");
        directed(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf");

        // A alone must not be accepted; B joining completes exactly one pair.
        @(posedge clk); #1;
        pops_before = n_pop;
        for (int c = 0; c < 4; c++) begin
            a_valid = 1'b1; b_valid = 1'b0;
            a_payload = 32'h40400000; b_payload = 32'h40A00000;
            @(negedge clk);
            check("a_alone_a_ready", 36'(a_ready), 36'd0);
            check("a_alone_b_ready", 36'(b_ready), 36'd1);
            @(posedge clk); #1;
        end
        b_valid = 1'b1;
        @(negedge clk);
        check("join_a_ready", 36'(a_ready), 36'd1);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (STAGES + 1) @(posedge clk);
        @(negedge clk);
        check("join_one_result", 36'(n_pop - pops_before), 36'd1);

        // 20-pair stream with the consumer stalled for cycles 5..14.
        for (int i = 0; i < 20; i++) begin
            ops_a[i] = rand_op();
            ops_b[i] = rand_op();
        end
        idx = 0;
        pops_before = n_pop;
        for (int c = 0; c < 200 && (idx < 20 || exp_q.size() > 0); c++) begin
            @(posedge clk); #1;
            o_ready = !(c >= 5 && c <= 14);
            a_valid = (idx < 20); b_valid = (idx < 20);
            if (idx < 20) begin
                a_payload = ops_a[idx]; b_payload = ops_b[idx];
            end
            @(negedge clk);
            if (a_valid && b_valid && a_ready) idx++;
            #1;
            if (c >= 5 && c <= 14) begin
                check("full_a_ready", 36'(a_ready), 36'd0);
                check("full_occupancy", 36'(exp_q.size()), 36'(STAGES));
            end
        end
        check("stream_all_accepted", 36'(idx), 36'd20);
        check("stream_all_returned", 36'(n_pop - pops_before), 36'd20);

        // Free-running random traffic with independent valids and backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            a_payload = rand_op();
            b_payload = rand_op();
            o_ready   = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
        repeat (STAGES + 2) @(posedge clk);
        @(negedge clk);
        check("random_drained", 36'(exp_q.size()), 36'd0);

        // Reset with two entries in flight.
        @(posedge clk); #1;
        o_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_payload = 32'h40000000; b_payload = 32'h40400000;
        @(posedge clk); #1;
        a_payload = 32'h40800000;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_o_valid", 36'(o_valid), 36'd0);
        check("mid_rst_a_ready", 36'(a_ready), 36'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("post_rst_o_valid", 36'(o_valid), 36'd0);
        check("post_rst_busy", 36'(busy), 36'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_stale", 36'(o_valid), 36'd0);
        end
        directed(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "post_rst_fresh");
        @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
